// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [4:0] {
    OpBeq  = 5'd0,
    OpBne  = 5'd1,
    OpBlt  = 5'd2,
    OpBge  = 5'd3,
    OpBltu = 5'd4,
    OpBgeu = 5'd5,
    OpAdd  = 5'd6,
    OpSub  = 5'd7,
    OpSll  = 5'd8,
    OpSlt  = 5'd9,
    OpSltu = 5'd10,
    OpXor  = 5'd11,
    OpSrl  = 5'd12,
    OpSra  = 5'd13,
    OpOr   = 5'd14,
    OpAnd  = 5'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift,
    StDone
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return op inside {OpSll, OpSrl, OpSra};
  endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA, loaded with operand and amount,
// then stepped until the count runs out.
module alu_shift_serial #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               soc_clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               left,
  input  logic               arith,
  input  logic [XLEN-1:0]    din,
  input  logic [SHAMT_W-1:0] amt,
  output logic [XLEN-1:0]    shifted,
  output logic               done
);

  logic [XLEN-1:0]    data_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               left_q;
  logic               arith_q;

  always_comb begin
    shifted = left_q ? {data_q[XLEN-2:0], 1'b0}
                     : {arith_q & data_q[XLEN-1], data_q[XLEN-1:1]};
  end

  // High during the step that takes the counter to zero, so the caller can
  // capture the final value without an extra cycle.
  assign done = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      data_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      data_q  <= din;
      cnt_q   <= amt;
      left_q  <= left;
      arith_q <= arith;
    end else if (step && cnt_q != '0) begin
      data_q <= shifted;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, one operation in flight.
// Define ALU_SEQ_SERIAL_SHIFT_EN to replace the barrel shifter with a serial one.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            soc_clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] dat1,
  input  logic [XLEN-1:0] dat2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            con_met,
  output logic            zero,
  output logic            err
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  alu_state_e state_q, state_d;
  alu_op_e    op_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic ovf_q, con_q, zero_q, err_q;

  logic [XLEN-1:0]    sum, diff, exe_res;
  logic [SHAMT_W-1:0] shamt;
  logic eq, lt_s, lt_u;
  logic exe_ovf, exe_con, exe_zero, exe_err;
  logic accept, cap_exec;

  assign shamt = b_q[SHAMT_W-1:0];
  assign sum   = a_q + b_q;
  assign diff  = a_q - b_q;
  assign eq    = (a_q == b_q);
  assign lt_s  = ($signed(a_q) < $signed(b_q));
  assign lt_u  = (a_q < b_q);

  always_comb begin
    exe_res = '0;
    exe_ovf = 1'b0;
    exe_con = 1'b0;
    exe_err = 1'b0;
    case (op_q)
      OpBeq:  exe_con = eq;
      OpBne:  exe_con = ~eq;
      OpBlt:  exe_con = lt_s;
      OpBge:  exe_con = ~lt_s;
      OpBltu: exe_con = lt_u;
      OpBgeu: exe_con = ~lt_u;
      OpAdd: begin
        exe_res = sum;
        exe_ovf = (a_q[XLEN-1] == b_q[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
      end
      OpSub: begin
        exe_res = diff;
        exe_ovf = (a_q[XLEN-1] != b_q[XLEN-1]) && (diff[XLEN-1] != a_q[XLEN-1]);
      end
      OpSlt: begin
        exe_res = {{(XLEN-1){1'b0}}, lt_s};
        exe_con = lt_s;
      end
      OpSltu: begin
        exe_res = {{(XLEN-1){1'b0}}, lt_u};
        exe_con = lt_u;
      end
      OpXor: exe_res = a_q ^ b_q;
      OpOr:  exe_res = a_q | b_q;
      OpAnd: exe_res = a_q & b_q;
`ifdef ALU_SEQ_SERIAL_SHIFT_EN
      // Only zero-amount shifts complete here; the rest go through StShift.
      OpSll, OpSrl, OpSra: exe_res = a_q;
`else
      OpSll: exe_res = a_q << shamt;
      OpSrl: exe_res = a_q >> shamt;
      OpSra: exe_res = $signed(a_q) >>> shamt;
`endif
      default: exe_err = 1'b1;
    endcase
    exe_zero = (op_q > OpBgeu) && !exe_err && (exe_res == '0);
  end

`ifdef ALU_SEQ_SERIAL_SHIFT_EN
  logic            shift_load, shift_step, shift_done, cap_shift;
  logic [XLEN-1:0] shift_val;

  alu_shift_serial #(
    .XLEN(XLEN)
  ) u_shift (
    .soc_clk (soc_clk),
    .reset   (reset),
    .load    (shift_load),
    .step    (shift_step),
    .left    (op_q == OpSll),
    .arith   (op_q == OpSra),
    .din     (a_q),
    .amt     (shamt),
    .shifted (shift_val),
    .done    (shift_done)
  );
`endif

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cap_exec = 1'b0;
`ifdef ALU_SEQ_SERIAL_SHIFT_EN
    shift_load = 1'b0;
    shift_step = 1'b0;
    cap_shift  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
`ifdef ALU_SEQ_SERIAL_SHIFT_EN
        if (is_shift(op_q) && shamt != '0) begin
          shift_load = 1'b1;
          state_d    = StShift;
        end else begin
          cap_exec = 1'b1;
          state_d  = StDone;
        end
`else
        cap_exec = 1'b1;
        state_d  = StDone;
`endif
      end
      StShift: begin
`ifdef ALU_SEQ_SERIAL_SHIFT_EN
        shift_step = 1'b1;
        if (shift_done) begin
          cap_shift = 1'b1;
          state_d   = StDone;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpBeq;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      con_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= alu_op_e'(op);
        a_q  <= dat1;
        b_q  <= dat2;
      end
      if (cap_exec) begin
        res_q  <= exe_res;
        ovf_q  <= exe_ovf;
        con_q  <= exe_con;
        zero_q <= exe_zero;
        err_q  <= exe_err;
      end
`ifdef ALU_SEQ_SERIAL_SHIFT_EN
      if (cap_shift) begin
        res_q  <= shift_val;
        ovf_q  <= 1'b0;
        con_q  <= 1'b0;
        zero_q <= (shift_val == '0);
        err_q  <= 1'b0;
      end
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign con_met   = con_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: handshake latency, flags, back-pressure
// and reset abort.
module tb_alu_seq;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [31:0] dat1 = '0;
  logic [31:0] dat2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow, con_met, zero, err;

  int tests = 0;
  int fails = 0;

`ifdef ALU_SEQ_SERIAL_SHIFT_EN
  localparam int SraLat = 6;
`else
  localparam int SraLat = 2;
`endif

  alu_seq #(
    .XLEN(32)
  ) dut (
    .soc_clk   (soc_clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dat1      (dat1),
    .dat2      (dat2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .con_met   (con_met),
    .zero      (zero),
    .err       (err)
  );

  always #5 soc_clk = ~soc_clk;

  // Issues one request and returns the number of cycles until out_valid.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    int guard;
    guard = 0;
    @(negedge soc_clk);
    while (!in_ready && guard < 50) begin
      @(negedge soc_clk);
      guard++;
    end
    in_valid = 1'b1;
    op       = o;
    dat1     = a;
    dat2     = b;
    @(negedge soc_clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge soc_clk);
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge soc_clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge soc_clk);
    reset = 1'b0;
    @(negedge soc_clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    tests++;
    if (result !== 32'h0 || {overflow, con_met, zero, err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: result=%h flags=%b, want 0 0000", result,
               {overflow, con_met, zero, err});
    end
  endtask

  task automatic test_add();
    int n;
    run_op(5'd6, 32'h7FFF_FFFF, 32'h1, n);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL add_latency: got %0d cycles, want 2", n);
    end
    tests++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL add_overflow: result=%h ovf=%b zero=%b err=%b, want 80000000 1 0 0",
               result, overflow, zero, err);
    end
    release_out();
  endtask

  task automatic test_sub_branch();
    int n;
    run_op(5'd7, 32'h1234, 32'h1234, n);
    tests++;
    if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL sub_zero: result=%h zero=%b ovf=%b, want 0 1 0", result, zero, overflow);
    end
    release_out();
    run_op(5'd2, 32'hFFFF_FFFF, 32'h1, n);
    tests++;
    if (result !== 32'h0 || con_met !== 1'b1 || zero !== 1'b0 || n !== 2) begin
      fails++;
      $display("FAIL blt: result=%h con=%b zero=%b lat=%0d, want 0 1 0 2", result, con_met,
               zero, n);
    end
    release_out();
    run_op(5'd4, 32'hFFFF_FFFF, 32'h1, n);
    tests++;
    if (result !== 32'h0 || con_met !== 1'b0) begin
      fails++;
      $display("FAIL bltu: result=%h con=%b, want 0 0", result, con_met);
    end
    release_out();
  endtask

  task automatic test_shift();
    int n;
    run_op(5'd13, 32'h8000_0000, 32'd4, n);
    tests++;
    if (result !== 32'hF800_0000 || n !== SraLat) begin
      fails++;
      $display("FAIL sra4: result=%h lat=%0d, want f8000000 %0d", result, n, SraLat);
    end
    release_out();
    run_op(5'd13, 32'h8000_0000, 32'd0, n);
    tests++;
    if (result !== 32'h8000_0000 || n !== 2) begin
      fails++;
      $display("FAIL sra0: result=%h lat=%0d, want 80000000 2", result, n);
    end
    release_out();
    run_op(5'd8, 32'h1, 32'd31, n);
    tests++;
    if (result !== 32'h8000_0000 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL sll31: result=%h ovf=%b, want 80000000 0", result, overflow);
    end
    release_out();
    // Only the low five bits of dat2 form the amount: 0x24 shifts by 4.
    run_op(5'd12, 32'h8000_0000, 32'h24, n);
    tests++;
    if (result !== 32'h0800_0000) begin
      fails++;
      $display("FAIL srl_mask: result=%h, want 08000000", result);
    end
    release_out();
  endtask

  task automatic test_logic();
    int n;
    run_op(5'd9, 32'hFFFF_FFFF, 32'h1, n);
    tests++;
    if (result !== 32'h1 || con_met !== 1'b1 || zero !== 1'b0) begin
      fails++;
      $display("FAIL slt: result=%h con=%b zero=%b, want 1 1 0", result, con_met, zero);
    end
    release_out();
    run_op(5'd11, 32'hA5A5_5A5A, 32'hA5A5_5A5A, n);
    tests++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      fails++;
      $display("FAIL xor_zero: result=%h zero=%b, want 0 1", result, zero);
    end
    release_out();
    run_op(5'd15, 32'hFF00_F0F0, 32'h0FF0_3C3C, n);
    tests++;
    if (result !== 32'h0F00_3030 || zero !== 1'b0) begin
      fails++;
      $display("FAIL and: result=%h zero=%b, want 0f003030 0", result, zero);
    end
    release_out();
  endtask

  task automatic test_illegal();
    int n;
    run_op(5'd20, 32'h1234_5678, 32'h9ABC_DEF0, n);
    tests++;
    if (err !== 1'b1 || result !== 32'h0 || {overflow, con_met, zero} !== 3'b000 || n !== 2)
    begin
      fails++;
      $display("FAIL illegal: err=%b result=%h ocz=%b lat=%0d, want 1 0 000 2", err, result,
               {overflow, con_met, zero}, n);
    end
    release_out();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL illegal_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    run_op(5'd6, 32'd5, 32'd3, n);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op       = 5'd14;
      dat1     = 32'hFFFF_0000;
      dat2     = 32'h0000_FFFF;
      @(negedge soc_clk);
      if (result !== 32'd8 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_done: %0d of 5 stalled cycles wrong, want 0", bad);
    end
    in_valid = 1'b0;
    release_out();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd8) begin
      fails++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b result=%h, want 1 0 8", in_ready,
               out_valid, result);
    end
    @(negedge soc_clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_ignored: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    @(negedge soc_clk);
    in_valid = 1'b1;
    op       = 5'd13;
    dat1     = 32'h8000_0000;
    dat2     = 32'd8;
    @(negedge soc_clk);
    in_valid = 1'b0;
    @(negedge soc_clk);
    reset = 1'b1;
    @(negedge soc_clk);
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        {overflow, con_met, zero, err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_abort: in_ready=%b out_valid=%b result=%h flags=%b, want 1 0 0 0000",
               in_ready, out_valid, result, {overflow, con_met, zero, err});
    end
    repeat (10) @(negedge soc_clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_result: out_valid=%b, want 0", out_valid);
    end
    run_op(5'd14, 32'hF0, 32'h0F, n);
    tests++;
    if (result !== 32'hFF || n !== 2 || zero !== 1'b0) begin
      fails++;
      $display("FAIL or_after_reset: result=%h lat=%0d zero=%b, want ff 2 0", result, n, zero);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_shift();
    test_logic();
    test_illegal();
    test_backpressure();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 8..64.
REQ-002 SHALL have derived localparam SHAMT_W, equal to $clog2(XLEN), the shift-amount width.
REQ-003 SHALL have port soc_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have port op, input, 5 bits: operation code, per REQ-014.
REQ-008 SHALL have ports dat1 and dat2, inputs, XLEN bits each: operands.
REQ-009 SHALL have port out_valid, output, 1 bit: result and flags valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN bits: operation result.
REQ-012 SHALL have ports overflow, con_met, zero and err, outputs, 1 bit each: status flags.

Function
REQ-013 SHALL sample op, dat1 and dat2 into internal registers on a transfer, i.e. a cycle with in_valid=1 and in_ready=1; inputs are ignored at all other times.
REQ-014 SHALL use this op encoding:
- 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU
- 6 ADD, 7 SUB, 8 SLL, 9 SLT, 10 SLTU, 11 XOR
- 12 SRL, 13 SRA, 14 OR, 15 AND
- 16-31 illegal
REQ-015 SHALL implement a state machine with states IDLE, EXEC, SHIFT and DONE:
- IDLE goes to EXEC on a transfer.
- EXEC goes to SHIFT for ops 8, 12 and 13 when serial shifting is compiled in (REQ-029) and the shift amount is non-zero; otherwise EXEC goes to DONE.
- SHIFT goes to DONE when its counter reaches 0.
- DONE goes to IDLE when out_ready=1.
REQ-016 SHALL drive in_ready=1 only in IDLE; there is exactly one operation in flight.
REQ-017 SHALL drive out_valid=1 only in DONE; result and all flags are registered and held stable throughout DONE.
REQ-018 SHALL assert out_valid 2 cycles after the transfer cycle for every non-serial operation.
REQ-019 SHALL, for branch ops 0-5, drive result=0 and set con_met to the branch condition (signed comparison for 2/3, unsigned for 4/5).
REQ-020 SHALL, for SLT and SLTU, drive result as 1 or 0 zero-extended to XLEN, with con_met equal to result[0].
REQ-021 SHALL compute ADD/SUB modulo 2^XLEN and set overflow to the signed two's-complement overflow; overflow=0 for all other ops.
REQ-022 SHALL take the shift amount from dat2[SHAMT_W-1:0]; SRA replicates dat1[XLEN-1].
REQ-023 SHALL set zero=(result==0) for ops 6-15 and zero=0 for ops 0-5.
REQ-024 SHALL, for illegal ops, drive result=0, err=1 and all other flags 0, and still complete the handshake with REQ-018 latency.
REQ-025 SHALL hold DONE indefinitely while out_ready=0; in_valid asserted during that time is not accepted.

Reset
REQ-026 SHALL, when reset=1 is sampled, enter IDLE and clear result, the flags, out_valid, the operand registers and the shift counter.
REQ-027 SHALL abort any in-flight operation on reset, including one in EXEC, SHIFT or DONE; no result is produced for it.
REQ-028 SHALL have in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL use macro ALU_SEQ_SERIAL_SHIFT_EN to select the shifter:
- Defined: shifts are performed one bit per cycle in SHIFT, so out_valid arrives 2+shamt cycles after the transfer.
- Not defined: a single-cycle barrel shifter is used in EXEC, the SHIFT state is unreachable, and latency is 2 for all ops.

Structure
REQ-030 SHALL place the op enum (alu_op_e, values 0-31) and the state enum (alu_state_e) in shared package alu_pkg.
REQ-031 SHALL implement serial shifting in sub-module alu_shift_serial (load, step and done signals, XLEN parameter); all other function units stay inline in alu_seq.

Verification
REQ-032 SHALL cover: ADD with XLEN=32, dat1=0x7FFFFFFF, dat2=1 -> result=0x80000000, overflow=1, zero=0, out_valid 2 cycles after the transfer.
REQ-033 SHALL cover: SUB with dat1=dat2=0x1234 -> result=0, zero=1; then BLT with dat1=0xFFFFFFFF, dat2=1 -> con_met=1, result=0; BLTU with the same operands -> con_met=0.
REQ-034 SHALL cover: SRA with dat1=0x80000000, dat2=4 -> result=0xF8000000; with ALU_SEQ_SERIAL_SHIFT_EN defined, out_valid arrives 6 cycles after the transfer, and with shamt=0, 2 cycles after.
REQ-035 SHALL cover: op=20 -> err=1, result=0, and the handshake completes normally.
REQ-036 SHALL cover: out_ready held at 0 for 5 cycles -> result is stable, in_ready=0, and a new in_valid is ignored; releasing out_ready gives in_ready=1 on the next cycle.
REQ-037 SHALL cover: reset pulsed during SHIFT -> next cycle state is IDLE, out_valid=0 and all outputs are 0; a subsequent OR of 0xF0 and 0x0F gives 0xFF.
